csr_regfile: RTL and testbench

//   Control/status register file answering the writeback stage's CSR read/write port and exception/ertn commit signals.

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_timer.sv | 53 +++++
 rtl/csr_regfile.sv | 196 +++++++++++++++++++
 tb/tb_csr_regfile.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map, exception codes and field positions for the CSR register file.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_ADEF = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0B,
        ECODE_BRK  = 6'h0C,
        ECODE_INE  = 6'h0D
    } ecode_e;

    // Field positions inside TCFG.
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;

    // LIE bit 10 never exists; bit 11 only exists with the timer.
    localparam logic [12:0] LIE_WMASK_TIMER = 13'h1BFF;
    localparam logic [12:0] LIE_WMASK_BASE  = 13'h13FF;
    localparam logic [31:0] EENTRY_WMASK    = 32'hFFFF_FFC0;

    function automatic logic [31:0] masked_merge(input logic [31:0] old_val,
                                                 input logic [31:0] wvalue,
                                                 input logic [31:0] wmask);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer producing the timer interrupt status bit ESTAT.IS[11].
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_tcfg_we,
    input  logic [31:0] i_tcfg_wdata,
    input  logic        i_ticlr,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_ti
);

    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic        r_ti;
    logic        w_en;
    logic        w_expire;

    assign w_en     = r_tcfg[TCFG_EN];
    // A TCFG write in the expiry cycle restarts the count and suppresses the interrupt.
    assign w_expire = w_en && (r_tval == 32'd1) && !i_tcfg_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcfg <= '0;
            r_tval <= '0;
            r_ti   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            if (i_tcfg_we) begin
                r_tcfg <= i_tcfg_wdata;
                r_tval <= {i_tcfg_wdata[31:2], 2'b00};
            end else if (w_en && (r_tval != 32'd0)) begin
                if (r_tval == 32'd1)
                    r_tval <= r_tcfg[TCFG_PERIODIC] ? {r_tcfg[31:2], 2'b00} : 32'd0;
                else
                    r_tval <= r_tval - 32'd1;
            end

            if (i_ticlr)
                r_ti <= 1'b0;
            else if (w_expire)
                r_ti <= 1'b1;
        end
    end

    assign o_tcfg = r_tcfg;
    assign o_tval = r_tval;
    assign o_ti   = r_ti;

endmodule

// File: rtl/csr_regfile.sv
// CSR register file for the writeback stage: masked CSR writes, exception/ertn commit, interrupts.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the timer interrupt.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] TID_INIT = 32'h0,
    parameter int          HWI_W    = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             csr_re,
    input  logic [13:0]      csr_num,
    output logic [31:0]      csr_rvalue,
    input  logic             csr_we,
    input  logic [31:0]      csr_wmask,
    input  logic [31:0]      csr_wvalue,
    input  logic             wb_ex,
    input  logic [5:0]       wb_ecode,
    input  logic [8:0]       wb_esubcode,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_vaddr,
    input  logic             ertn_flush,
    input  logic [HWI_W-1:0] hw_int_in,
    input  logic             ipi_int_in,
    output logic [31:0]      ex_entry,
    output logic [31:0]      ertn_entry,
    output logic             has_int
);

    logic [1:0]  r_crmd_plv;
    logic        r_crmd_ie;
    logic [1:0]  r_prmd_pplv;
    logic        r_prmd_pie;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_ipi;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [31:0] r_eentry;
    logic [31:0] r_save [4];

    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic [12:0] w_is;
    logic [12:0] w_lie_wmask;
    logic        w_ti;
    logic [7:0]  w_hwi;

    assign w_hwi = 8'(hw_int_in);
    assign w_is  = {r_is_ipi, w_ti, 1'b0, r_is_hw, r_is_sw};

`ifdef CSR_TIMER_EN
    logic [31:0] r_tid;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;

    assign w_lie_wmask = LIE_WMASK_TIMER;

    csr_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_tcfg_we    (csr_we && (csr_num == CSR_TCFG)),
        .i_tcfg_wdata (w_merged),
        .i_ticlr      (csr_we && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0]),
        .o_tcfg       (w_tcfg),
        .o_tval       (w_tval),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tid <= TID_INIT;
        else if (csr_we && (csr_num == CSR_TID))
            r_tid <= w_merged;
    end
`else
    logic [31:0] w_unused_tid_init;

    assign w_unused_tid_init = TID_INIT;
    assign w_lie_wmask       = LIE_WMASK_BASE;
    assign w_ti              = 1'b0;
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives w_rdata and no latch is inferred.
        w_rdata = '0;
        case (csr_num)
            CSR_CRMD:   w_rdata = {28'h0, 1'b1, r_crmd_ie, r_crmd_plv};
            CSR_PRMD:   w_rdata = {29'h0, r_prmd_pie, r_prmd_pplv};
            CSR_ECFG:   w_rdata = {19'h0, r_ecfg_lie};
            CSR_ESTAT:  w_rdata = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};
            CSR_ERA:    w_rdata = r_era;
            CSR_BADV:   w_rdata = r_badv;
            CSR_EENTRY: w_rdata = r_eentry;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        w_rdata = r_save[csr_num[1:0]];
`ifdef CSR_TIMER_EN
            CSR_TID:    w_rdata = r_tid;
            CSR_TCFG:   w_rdata = w_tcfg;
            CSR_TVAL:   w_rdata = w_tval;
`endif
            default:    w_rdata = '0;
        endcase
    end

    // Merging against the addressed CSR's current read value; each register keeps only its writable bits.
    assign w_merged   = masked_merge(w_rdata, csr_wvalue, csr_wmask);
    assign csr_rvalue = csr_re ? w_rdata : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crmd_plv  <= 2'd0;
            r_crmd_ie   <= 1'b0;
            r_prmd_pplv <= 2'd0;
            r_prmd_pie  <= 1'b0;
        end else begin
            if (wb_ex) begin
                r_crmd_plv <= 2'd0;
                r_crmd_ie  <= 1'b0;
            end else if (ertn_flush) begin
                r_crmd_plv <= r_prmd_pplv;
                r_crmd_ie  <= r_prmd_pie;
            end else if (csr_we && (csr_num == CSR_CRMD)) begin
                r_crmd_plv <= w_merged[1:0];
                r_crmd_ie  <= w_merged[2];
            end

            if (wb_ex) begin
                r_prmd_pplv <= r_crmd_plv;
                r_prmd_pie  <= r_crmd_ie;
            end else if (csr_we && (csr_num == CSR_PRMD)) begin
                r_prmd_pplv <= w_merged[1:0];
                r_prmd_pie  <= w_merged[2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ecfg_lie <= '0;
            r_is_sw    <= '0;
            r_is_hw    <= '0;
            r_is_ipi   <= 1'b0;
            r_ecode    <= '0;
            r_esubcode <= '0;
        end else begin
            r_is_hw  <= w_hwi;
            r_is_ipi <= ipi_int_in;
            if (csr_we && (csr_num == CSR_ECFG))
                r_ecfg_lie <= w_merged[12:0] & w_lie_wmask;
            if (csr_we && (csr_num == CSR_ESTAT))
                r_is_sw <= w_merged[1:0];
            if (wb_ex) begin
                r_ecode    <= wb_ecode;
                r_esubcode <= wb_esubcode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_era    <= '0;
            r_badv   <= '0;
            r_eentry <= '0;
            // NOTE: SAVE0-3 are ordinary flops, not a RAM, so they are cleared with the rest of the state.
            for (int i = 0; i < 4; i++)
                r_save[i] <= '0;
        end else begin
            if (wb_ex)
                r_era <= wb_pc;
            else if (csr_we && (csr_num == CSR_ERA))
                r_era <= w_merged;

            if (wb_ex && (wb_ecode == ECODE_ADEF))
                r_badv <= wb_pc;
            else if (wb_ex && (wb_ecode == ECODE_ALE))
                r_badv <= wb_vaddr;
            else if (csr_we && (csr_num == CSR_BADV))
                r_badv <= w_merged;

            if (csr_we && (csr_num == CSR_EENTRY))
                r_eentry <= w_merged & EENTRY_WMASK;
            if (csr_we && (csr_num[13:2] == CSR_SAVE0[13:2]))
                r_save[csr_num[1:0]] <= w_merged;
        end
    end

    assign ex_entry   = r_eentry;
    assign ertn_entry = r_era;
    assign has_int    = (|(w_is & r_ecfg_lie)) & r_crmd_ie;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: word-level CSR model, per-cycle compare, directed and random stimulus.
module tb_csr_regfile;

`ifdef CSR_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [31:0] TID_INIT = 32'h0;

    localparam int A_CRMD = 'h0, A_PRMD = 'h1, A_ECFG = 'h4, A_ESTAT = 'h5, A_ERA = 'h6;
    localparam int A_BADV = 'h7, A_EENTRY = 'hC, A_SAVE0 = 'h30, A_TID = 'h40;
    localparam int A_TCFG = 'h41, A_TVAL = 'h42, A_TICLR = 'h44;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_rvalue;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic        wb_ex = 1'b0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_vaddr = '0;
    logic        ertn_flush = 1'b0;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    always #5 clk = ~clk;

    csr_regfile #(.TID_INIT(TID_INIT), .HWI_W(8)) dut (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in),
        .ipi_int_in(ipi_int_in), .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: one 32-bit word per CSR address.
    logic [31:0] m [0:127];

    function automatic bit impl(input int a);
        if (a == A_CRMD || a == A_PRMD || a == A_ECFG || a == A_ESTAT || a == A_ERA ||
            a == A_BADV || a == A_EENTRY || (a >= A_SAVE0 && a <= A_SAVE0 + 3))
            return 1'b1;
        if (TIMER && (a == A_TID || a == A_TCFG || a == A_TVAL || a == A_TICLR))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] writable(input int a);
        if (!impl(a)) return 32'h0;
        case (a)
            A_CRMD, A_PRMD: return 32'h7;
            A_ECFG:         return TIMER ? 32'h1BFF : 32'h13FF;
            A_ESTAT:        return 32'h3;
            A_EENTRY:       return 32'hFFFF_FFC0;
            A_TVAL, A_TICLR: return 32'h0;
            default:        return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (!impl(a) || a == A_TICLR) return 32'h0;
        return m[a];
    endfunction

    function automatic logic exp_has_int();
        logic [31:0] is_v, lie_v;
        is_v  = m[A_ESTAT];
        lie_v = m[A_ECFG];
        return (|(is_v[12:0] & lie_v[12:0])) & m[A_CRMD][2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m[i] = 32'h0;
        m[A_CRMD] = 32'h8;
        m[A_TID]  = TID_INIT;
    endtask

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic model_clock();
        logic [31:0] o [0:127];
        logic [31:0] wm;
        logic        ti;
        int          a;
        if (reset) begin
            model_reset();
            return;
        end
        o  = m;
        a  = int'(csr_num);
        ti = o[A_ESTAT][11];
        if (csr_we && impl(a)) begin
            wm   = csr_wmask & writable(a);
            m[a] = (o[a] & ~wm) | (csr_wvalue & wm);
        end
        if (TIMER) begin
            if (csr_we && a == A_TCFG)
                m[A_TVAL] = {m[A_TCFG][31:2], 2'b00};
            else if (o[A_TCFG][0] && o[A_TVAL] != 0) begin
                if (o[A_TVAL] == 1) begin
                    ti = 1'b1;
                    m[A_TVAL] = o[A_TCFG][1] ? {o[A_TCFG][31:2], 2'b00} : 32'h0;
                end else
                    m[A_TVAL] = o[A_TVAL] - 1;
            end
            if (csr_we && a == A_TICLR && csr_wvalue[0] && csr_wmask[0]) ti = 1'b0;
        end
        if (ertn_flush) m[A_CRMD][2:0] = o[A_PRMD][2:0];
        if (wb_ex) begin
            m[A_PRMD][2:0]    = o[A_CRMD][2:0];
            m[A_CRMD][2:0]    = 3'b000;
            m[A_ERA]          = wb_pc;
            m[A_ESTAT][21:16] = wb_ecode;
            m[A_ESTAT][30:22] = wb_esubcode;
            if (wb_ecode == 6'h08) m[A_BADV] = wb_pc;
            if (wb_ecode == 6'h09) m[A_BADV] = wb_vaddr;
        end
        m[A_ESTAT][9:2] = hw_int_in;
        m[A_ESTAT][10]  = 1'b0;
        m[A_ESTAT][11]  = TIMER ? ti : 1'b0;
        m[A_ESTAT][12]  = ipi_int_in;
    endtask

    task automatic compare();
        check("rvalue", csr_rvalue, csr_re ? exp_read(int'(csr_num)) : 32'h0);
        check("ex_entry", ex_entry, m[A_EENTRY]);
        check("ertn_entry", ertn_entry, m[A_ERA]);
        check("has_int", {31'h0, has_int}, {31'h0, exp_has_int()});
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] v, input logic [31:0] mk);
        csr_we = 1'b1; csr_num = 14'(a); csr_wvalue = v; csr_wmask = mk;
        cyc();
        csr_we = 1'b0;
    endtask

    task automatic rd_lit(input string name, input int a, input logic [31:0] exp);
        csr_re = 1'b1; csr_num = 14'(a);
        #1;
        check(name, csr_rvalue, exp);
    endtask

    function automatic logic [13:0] pick_addr();
        case ($urandom_range(0, 19))
            0: return 14'(A_CRMD);    1: return 14'(A_PRMD);   2: return 14'(A_ECFG);
            3: return 14'(A_ESTAT);   4: return 14'(A_ERA);    5: return 14'(A_BADV);
            6: return 14'(A_EENTRY);  7: return 14'(A_SAVE0);  8: return 14'(A_SAVE0 + 1);
            9: return 14'(A_SAVE0 + 2); 10: return 14'(A_SAVE0 + 3); 11: return 14'(A_TID);
            12: return 14'(A_TCFG);   13: return 14'(A_TVAL);  14: return 14'(A_TICLR);
            15: return 14'(A_TCFG);   16: return 14'(A_TICLR);
            default: return 14'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_ecode();
        case ($urandom_range(0, 6))
            0: return 6'h00; 1: return 6'h08; 2: return 6'h09; 3: return 6'h0B;
            4: return 6'h0C; 5: return 6'h0D;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        model_reset();
        #2;
        rd_lit("reset_crmd", A_CRMD, 32'h8);
        check("reset_ex_entry", ex_entry, 32'h0);
        check("reset_ertn_entry", ertn_entry, 32'h0);
        check("reset_has_int", {31'h0, has_int}, 32'h0);
        cyc();
        reset = 1'b0;

        // EENTRY write; same-cycle read still returns the old value.
        csr_re = 1'b1; csr_num = 14'(A_EENTRY);
        csr_we = 1'b1; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h1C00_1234;
        #1;
        check("eentry_same_cycle", csr_rvalue, 32'h0);
        cyc();
        csr_we = 1'b0;
        rd_lit("eentry_read", A_EENTRY, 32'h1C00_1200);
        check("eentry_ex_entry", ex_entry, 32'h1C00_1200);

        // ALE exception then ertn.
        wr(A_CRMD, 32'h7, 32'hFFFF_FFFF);
        wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0010; wb_vaddr = 32'h3;
        cyc();
        wb_ex = 1'b0;
        rd_lit("ex_crmd", A_CRMD, 32'h8);
        rd_lit("ex_prmd", A_PRMD, 32'h7);
        rd_lit("ex_era", A_ERA, 32'h1C00_0010);
        rd_lit("ex_badv", A_BADV, 32'h3);
        csr_num = 14'(A_ESTAT);
        #1;
        v = csr_rvalue;
        check("ex_estat_ecode", {26'h0, v[21:16]}, 32'd9);
        ertn_flush = 1'b1;
        cyc();
        ertn_flush = 1'b0;
        rd_lit("ertn_crmd", A_CRMD, 32'hF);
        check("ertn_entry_val", ertn_entry, 32'h1C00_0010);

        // Hardware interrupt line 0 via LIE bit 2.
        wr(A_ECFG, 32'h4, 32'hFFFF_FFFF);
        hw_int_in = 8'h01;
        #1;
        check("hwi_before_edge", {31'h0, has_int}, 32'h0);
        cyc();
        check("hwi_has_int", {31'h0, has_int}, 32'h1);
        hw_int_in = 8'h00;
        cyc();

        // csr_we and wb_ex to CRMD in the same cycle: exception wins.
        csr_we = 1'b1; csr_num = 14'(A_CRMD); csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h7;
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_pc = 32'h1C00_0100;
        cyc();
        csr_we = 1'b0; wb_ex = 1'b0;
        rd_lit("prio_crmd", A_CRMD, 32'h8);
        rd_lit("prio_prmd", A_PRMD, 32'h7);
        rd_lit("prio_badv", A_BADV, 32'h3);

        wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_lit("lie_mask", A_ECFG, TIMER ? 32'h1BFF : 32'h13FF);

        if (TIMER) begin
            rd_lit("tid_init", A_TID, TID_INIT);
            wr(A_ECFG, 32'h800, 32'hFFFF_FFFF);
            wr(A_CRMD, 32'h4, 32'h4);
            wr(A_TCFG, 32'h13, 32'hFFFF_FFFF);
            rd_lit("tval_load", A_TVAL, 32'h10);
            for (int i = 0; i < 15; i++) cyc();
            check("timer_not_yet", {31'h0, has_int}, 32'h0);
            cyc();
            check("timer_fired", {31'h0, has_int}, 32'h1);
            rd_lit("tval_reload", A_TVAL, 32'h10);
            wr(A_TICLR, 32'h1, 32'h1);
            check("ticlr_clears", {31'h0, has_int}, 32'h0);
            rd_lit("ticlr_reads0", A_TICLR, 32'h0);
        end else begin
            wr(A_TCFG, 32'h13, 32'hFFFF_FFFF);
            rd_lit("no_timer_tcfg", A_TCFG, 32'h0);
            rd_lit("no_timer_tval", A_TVAL, 32'h0);
            wr(A_TID, 32'h1234_5678, 32'hFFFF_FFFF);
            rd_lit("no_timer_tid", A_TID, 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            csr_re      = ($urandom_range(0, 3) != 0);
            csr_num     = pick_addr();
            csr_we      = ($urandom_range(0, 2) == 0);
            csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom);
            csr_wvalue  = (csr_num == 14'(A_TCFG)) ? 32'($urandom_range(0, 63)) : 32'($urandom);
            wb_ex       = ($urandom_range(0, 15) == 0);
            wb_ecode    = pick_ecode();
            wb_esubcode = 9'($urandom);
            wb_pc       = 32'($urandom);
            wb_vaddr    = 32'($urandom);
            ertn_flush  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi_int_in = 1'($urandom);
            cyc();
        end
        csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        cyc();

        // Asynchronous reset in the middle of a countdown.
        wr(A_CRMD, 32'h7, 32'hFFFF_FFFF);
        if (TIMER) begin
            wr(A_TCFG, 32'h9, 32'hFFFF_FFFF);
            cyc();
            rd_lit("tval_mid", A_TVAL, 32'h7);
        end
        reset = 1'b1;
        model_reset();
        rd_lit("async_crmd", A_CRMD, 32'h8);
        check("async_has_int", {31'h0, has_int}, 32'h0);
        check("async_ex_entry", ex_entry, 32'h0);
        if (TIMER) rd_lit("async_tval", A_TVAL, 32'h0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
